// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl -- scan sequencer for a two-half HUB75 LED panel.
//
// The controller reads bit-planes from a synchronous framebuffer and shifts
// one row per plane into the panel. It then blanks the panel, latches the
// row and releases the blank. Each plane is displayed for ON_BASE << plane
// cycles (binary code modulation). The plane is the inner loop and the row
// the outer loop.
//
// Ports
//   clk                       system clock
//   rst                       synchronous, active-high reset
//   enable                    run the scan; sampled in IDLE and at frame end
//   pix_row/pix_col/pix_plane framebuffer address (registered)
//   pix_rgb0/pix_rgb1         {R,G,B} for the upper/lower half, 1 clk latency
//   R0in..B1in                panel colour data (registered)
//   A                         panel row address (registered)
//   SCLKin                    panel shift clock (registered)
//   BLANKin                   panel blank, 1 = dark
//   LATCHin                   panel latch strobe
//   frame_done                one-cycle pulse after the last row/plane latch
//
// All outputs are registered from next-state values, so each output lines
// up with the state it belongs to.

module hub75_scan_ctrl #(
    parameter int COLS         = 64,
    parameter int ADDR_BITS    = 5,
    parameter int BITS         = 4,
    parameter int ON_BASE      = 64,
    parameter int BLANK_CYCLES = 2,
    localparam int COL_W       = $clog2(COLS),
    localparam int PW          = (BITS > 1) ? $clog2(BITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic [ADDR_BITS-1:0] pix_row,
    output logic [COL_W-1:0]     pix_col,
    output logic [PW-1:0]        pix_plane,
    input  logic [2:0]           pix_rgb0,
    input  logic [2:0]           pix_rgb1,
    output logic                 R0in,
    output logic                 G0in,
    output logic                 B0in,
    output logic                 R1in,
    output logic                 G1in,
    output logic                 B1in,
    output logic [ADDR_BITS-1:0] A,
    output logic                 SCLKin,
    output logic                 BLANKin,
    output logic                 LATCHin,
    output logic                 frame_done
);

    // The shift phase runs for cycles 0 .. 2*COLS+1. The same counter also
    // times the blank phase, so it is sized for the longer of the two.
    localparam int SHIFT_LAST = 2 * COLS + 1;
    localparam int CNT_MAX    = (2 * COLS + 2 > BLANK_CYCLES) ? 2 * COLS + 2 : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX);
    localparam int TW         = $clog2((ON_BASE << (BITS - 1)) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK,
        S_LATCH,
        S_UNBLANK
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [TW-1:0]        timer, timer_d;
    logic [ADDR_BITS-1:0] row_d, a_d;
    logic [COL_W-1:0]     col_d;
    logic [PW-1:0]        plane_d;
    logic [2:0]           rgb0_q, rgb1_q, rgb0_d, rgb1_d;
    logic                 sclk_d, blank_d, latch_d, done_d;
    logic                 disp_done, last_row, last_plane;

    assign {R0in, G0in, B0in} = rgb0_q;
    assign {R1in, G1in, B1in} = rgb1_q;

    // The timer reaches zero on the next cycle. The blank therefore starts
    // exactly when the display time runs out.
    assign disp_done  = (timer <= TW'(1));
    assign last_row   = (pix_row == '1);
    assign last_plane = (pix_plane == PW'(BITS - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case statement. If a
        // path skipped an assignment, synthesis would infer a latch.
        state_d = state;
        cnt_d   = cnt;
        timer_d = (timer != '0) ? timer - 1'b1 : '0;
        row_d   = pix_row;
        col_d   = pix_col;
        plane_d = pix_plane;
        rgb0_d  = rgb0_q;
        rgb1_d  = rgb1_q;
        a_d     = A;
        blank_d = BLANKin;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        done_d  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end

            S_SHIFT: begin
                if (cnt == CNT_W'(SHIFT_LAST)) begin
                    cnt_d = '0;
                    if (disp_done) begin
                        state_d = S_BLANK;
                        blank_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d  = cnt + 1'b1;
                    // SCLK is high in the odd cycles from 3 on. Data for each
                    // pulse lands one cycle earlier.
                    sclk_d = !cnt[0] && (cnt >= CNT_W'(2));
                    // In an odd cycle, data for the current column returns.
                    // Capture it and step to the next column. The last step
                    // wraps the column back to 0.
                    if (cnt[0] && (cnt < CNT_W'(2 * COLS))) begin
                        rgb0_d = pix_rgb0;
                        rgb1_d = pix_rgb1;
                        col_d  = pix_col + 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (disp_done) begin
                    state_d = S_BLANK;
                    blank_d = 1'b1;
                end
            end

            S_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                    a_d     = pix_row;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            S_LATCH: begin
                state_d = S_UNBLANK;
                blank_d = 1'b0;
                timer_d = TW'(ON_BASE << pix_plane);
                done_d  = last_row && last_plane;
            end

            S_UNBLANK: begin
                if (last_plane) begin
                    plane_d = '0;
                    row_d   = pix_row + 1'b1;
                end else begin
                    plane_d = pix_plane + 1'b1;
                end
                if (last_row && last_plane && !enable) begin
                    // Leaving the scan drops the last plane's display time.
                    state_d = S_IDLE;
                    blank_d = 1'b1;
                    rgb0_d  = '0;
                    rgb1_d  = '0;
                    a_d     = '0;
                    timer_d = '0;
                end else begin
                    state_d = S_SHIFT;
                end
                cnt_d = '0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from the values before the edge.
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            timer      <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            pix_plane  <= '0;
            rgb0_q     <= '0;
            rgb1_q     <= '0;
            A          <= '0;
            SCLKin     <= 1'b0;
            BLANKin    <= 1'b1;
            LATCHin    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            timer      <= timer_d;
            pix_row    <= row_d;
            pix_col    <= col_d;
            pix_plane  <= plane_d;
            rgb0_q     <= rgb0_d;
            rgb1_q     <= rgb1_d;
            A          <= a_d;
            SCLKin     <= sclk_d;
            BLANKin    <= blank_d;
            LATCHin    <= latch_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Testbench for hub75_scan_ctrl. A framebuffer model with one-cycle read
// latency feeds the DUT. A passive monitor records panel events: data at
// each SCLK rise, and the A value, pulse count, display time and blank run
// at each LATCH. Scenario tasks check those records against the expected
// scan order derived from the row/plane loop rules.

module tb_hub75_scan_ctrl;

    localparam int COLS         = 4;
    localparam int ADDR_BITS    = 1;
    localparam int BITS         = 2;
    localparam int ON_BASE      = 16;
    localparam int BLANK_CYCLES = 2;
    localparam int ROWS         = 1 << ADDR_BITS;
    localparam int LPF          = ROWS * BITS;   // latches per frame

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 enable = 1'b0;
    logic [ADDR_BITS-1:0] pix_row;
    logic [1:0]           pix_col;
    logic [0:0]           pix_plane;
    logic [2:0]           pix_rgb0 = '0;
    logic [2:0]           pix_rgb1 = '0;
    logic                 R0in, G0in, B0in, R1in, G1in, B1in;
    logic [ADDR_BITS-1:0] A;
    logic                 SCLKin, BLANKin, LATCHin, frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hub75_scan_ctrl #(
        .COLS(COLS), .ADDR_BITS(ADDR_BITS), .BITS(BITS),
        .ON_BASE(ON_BASE), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_row(pix_row), .pix_col(pix_col), .pix_plane(pix_plane),
        .pix_rgb0(pix_rgb0), .pix_rgb1(pix_rgb1),
        .R0in(R0in), .G0in(G0in), .B0in(B0in),
        .R1in(R1in), .G1in(G1in), .B1in(B1in),
        .A(A), .SCLKin(SCLKin), .BLANKin(BLANKin), .LATCHin(LATCHin),
        .frame_done(frame_done)
    );

    // Synchronous framebuffer: the address is registered, data one clk later.
    logic [2:0] fb0 [ROWS][BITS][COLS];
    logic [2:0] fb1 [ROWS][BITS][COLS];

    always @(posedge clk) begin
        pix_rgb0 <= fb0[pix_row][pix_plane][pix_col];
        pix_rgb1 <= fb1[pix_row][pix_plane][pix_col];
    end

    // Monitor records
    typedef struct { int a; int pulses; int disp; int run; } latch_rec_t;
    typedef struct { logic blank; logic fd; } after_rec_t;

    latch_rec_t latch_q[$];
    after_rec_t after_q[$];
    logic [5:0] sclk_q[$];
    int         fd_count = 0;

    int   m_pulses = 0, m_disp = 0, m_run = 0;
    logic m_prev_sclk = 1'b0, m_pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_pulses    = 0;
            m_disp      = 0;
            m_run       = 0;
            m_prev_sclk = 1'b0;
            m_pend      = 1'b0;
        end else begin
            if (m_pend) begin
                after_q.push_back('{BLANKin, frame_done});
                m_pend = 1'b0;
            end
            if (frame_done) fd_count++;
            if (SCLKin && !m_prev_sclk) begin
                sclk_q.push_back({R0in, G0in, B0in, R1in, G1in, B1in});
                m_pulses++;
            end
            m_prev_sclk = SCLKin;
            if (BLANKin) m_run++;
            else begin
                m_run = 0;
                m_disp++;
            end
            if (LATCHin) begin
                latch_q.push_back('{int'(A), m_pulses, m_disp, m_run});
                m_pulses = 0;
                m_disp   = 0;
                m_pend   = 1'b1;
            end
        end
    end

    function automatic logic [14:0] outs();
        return {pix_row, pix_col, pix_plane, R0in, G0in, B0in, R1in, G1in, B1in,
                A, SCLKin, BLANKin, LATCHin, frame_done};
    endfunction

    localparam logic [14:0] IDLE_OUTS = 15'h0004;   // only BLANKin high

    task automatic clear_mon();
        latch_q.delete();
        after_q.delete();
        sclk_q.delete();
        fd_count = 0;
    endtask

    task automatic do_reset(input logic en);
        @(posedge clk); #1;
        rst = 1'b1;
        enable = en;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_latches(input int n, input int budget, output bit ok);
        int cyc = 0;
        while (latch_q.size() < n && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
        end
        ok = (latch_q.size() >= n);
    endtask

    // Reset held with enable=1. Only BLANKin is high. After release, the
    // first SCLK rise lands in shift cycle 3.
    task automatic test_reset();
        logic [3:0] sclk_seq;
        logic [1:0] col_c2;
        @(posedge clk); #1;
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            checks++;
            if (outs() !== IDLE_OUTS) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %h expected %h", i, outs(), IDLE_OUTS);
            end
        end
        rst = 1'b0;
        clear_mon();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            sclk_seq[c] = SCLKin;
            if (c == 2) col_c2 = pix_col;
        end
        checks++;
        if (sclk_seq !== 4'b1000) begin
            errors++;
            $display("FAIL first_sclk: got c0..c3=%b expected 0001", {sclk_seq[0], sclk_seq[1], sclk_seq[2], sclk_seq[3]});
        end
        checks++;
        if (col_c2 !== 2'd1) begin
            errors++;
            $display("FAIL pix_col_c2: got %0d expected 1", col_c2);
        end
    endtask

    // Column pattern: rgb0 = column, rgb1 = ~column.
    task automatic test_col_pattern();
        bit ok;
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BITS; p++)
                for (int k = 0; k < COLS; k++) begin
                    fb0[r][p][k] = 3'(k);
                    fb1[r][p][k] = ~3'(k);
                end
        do_reset(1'b1);
        wait_latches(LPF, 2000, ok);
        checks++;
        if (!ok || sclk_q.size() < LPF * COLS) begin
            errors++;
            $display("FAIL col_pattern_timeout: got %0d pulses expected %0d", sclk_q.size(), LPF * COLS);
        end else begin
            for (int i = 0; i < LPF * COLS; i++) begin
                logic [5:0] exp_v;
                exp_v = {3'(i % COLS), ~3'(i % COLS)};
                checks++;
                if (sclk_q[i] !== exp_v) begin
                    errors++;
                    $display("FAIL col_pattern pulse %0d: got %h expected %h", i, sclk_q[i], exp_v);
                end
            end
        end
    endtask

    // Random framebuffer contents across two frames, in the scan order
    // plane (inner), row (outer).
    task automatic test_random_data();
        bit ok;
        int n;
        n = 2 * LPF;
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BITS; p++)
                for (int k = 0; k < COLS; k++) begin
                    fb0[r][p][k] = 3'($urandom_range(7, 0));
                    fb1[r][p][k] = 3'($urandom_range(7, 0));
                end
        do_reset(1'b1);
        wait_latches(n, 3000, ok);
        checks++;
        if (!ok || sclk_q.size() < n * COLS) begin
            errors++;
            $display("FAIL random_data_timeout: got %0d pulses expected %0d", sclk_q.size(), n * COLS);
        end else begin
            for (int i = 0; i < n; i++) begin
                int row, plane;
                plane = i % BITS;
                row   = (i / BITS) % ROWS;
                for (int k = 0; k < COLS; k++) begin
                    logic [5:0] exp_v;
                    exp_v = {fb0[row][plane][k], fb1[row][plane][k]};
                    checks++;
                    if (sclk_q[i * COLS + k] !== exp_v) begin
                        errors++;
                        $display("FAIL random_data row %0d plane %0d col %0d: got %h expected %h",
                                 row, plane, k, sclk_q[i * COLS + k], exp_v);
                    end
                end
            end
        end
    endtask

    // Latch cadence: A sequence, pulses per row, BCM display time, blank run
    // around LATCH, and frame_done placement.
    task automatic test_bcm_timing();
        bit ok;
        int n;
        n = 2 * LPF;
        do_reset(1'b1);
        wait_latches(n, 3000, ok);
        @(negedge clk); #1;
        checks++;
        if (!ok || after_q.size() < n) begin
            errors++;
            $display("FAIL bcm_timeout: got %0d latches expected %0d", latch_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                int exp_disp;
                logic exp_fd;
                exp_disp = (i == 0) ? 0 : (ON_BASE << ((i - 1) % BITS));
                exp_fd   = ((i % LPF) == LPF - 1);
                checks++;
                if (latch_q[i].a != (i / BITS) % ROWS) begin
                    errors++;
                    $display("FAIL latch_a %0d: got %0d expected %0d", i, latch_q[i].a, (i / BITS) % ROWS);
                end
                checks++;
                if (latch_q[i].pulses != COLS) begin
                    errors++;
                    $display("FAIL sclk_per_row %0d: got %0d expected %0d", i, latch_q[i].pulses, COLS);
                end
                checks++;
                if (latch_q[i].disp != exp_disp) begin
                    errors++;
                    $display("FAIL display_time %0d: got %0d expected %0d", i, latch_q[i].disp, exp_disp);
                end
                if (i > 0) begin
                    checks++;
                    if (latch_q[i].run != BLANK_CYCLES + 1) begin
                        errors++;
                        $display("FAIL blank_run %0d: got %0d expected %0d", i, latch_q[i].run, BLANK_CYCLES + 1);
                    end
                end
                checks++;
                if (after_q[i].blank !== 1'b0 || after_q[i].fd !== exp_fd) begin
                    errors++;
                    $display("FAIL unblank %0d: got blank=%b fd=%b expected blank=0 fd=%b",
                             i, after_q[i].blank, after_q[i].fd, exp_fd);
                end
            end
            checks++;
            if (fd_count != n / LPF) begin
                errors++;
                $display("FAIL frame_done_count: got %0d expected %0d", fd_count, n / LPF);
            end
        end
    endtask

    // enable dropped mid-frame: the frame still completes, then the scan
    // stays in IDLE with the panel dark.
    task automatic test_enable_drop();
        bit ok;
        int cyc;
        do_reset(1'b1);
        wait_latches(1, 500, ok);
        @(posedge clk); #1;
        enable = 1'b0;
        cyc = 0;
        while (fd_count < 1 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (fd_count < 1) begin
            errors++;
            $display("FAIL enable_drop_timeout: got frame_done=%0d expected 1", fd_count);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            checks++;
            if (outs() !== IDLE_OUTS) begin
                errors++;
                $display("FAIL idle_after_frame cycle %0d: got %h expected %h", i, outs(), IDLE_OUTS);
            end
        end
        checks++;
        if (latch_q.size() != LPF || fd_count != 1) begin
            errors++;
            $display("FAIL enable_drop_frame: got latches=%0d fd=%0d expected latches=%0d fd=1",
                     latch_q.size(), fd_count, LPF);
        end
    endtask

    // rst during shift cycle 5 of a row-1 shift: the outputs reset at once,
    // and no latch occurs until a whole row has been reshifted.
    task automatic test_reset_mid_shift();
        bit ok;
        int cyc;
        int exp_cyc;
        do_reset(1'b1);
        wait_latches(3, 1000, ok);
        cyc = 0;
        while (sclk_q.size() < 3 * COLS + 2 && cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (!ok || sclk_q.size() < 3 * COLS + 2 || A !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_setup: got pulses=%0d A=%0d expected pulses=%0d A=1",
                     sclk_q.size(), A, 3 * COLS + 2);
        end
        rst = 1'b1;   // set during shift cycle 5
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL mid_shift_reset: got %h expected %h", outs(), IDLE_OUTS);
        end
        rst = 1'b0;
        clear_mon();
        exp_cyc = 2 * COLS + 2 + BLANK_CYCLES + 1;
        cyc = 0;
        while (latch_q.size() < 1 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (latch_q.size() < 1 || cyc != exp_cyc) begin
            errors++;
            $display("FAIL relatch_time: got cycle %0d expected %0d", cyc, exp_cyc);
        end else begin
            checks++;
            if (latch_q[0].a != 0 || latch_q[0].pulses != COLS) begin
                errors++;
                $display("FAIL relatch_row: got A=%0d pulses=%0d expected A=0 pulses=%0d",
                         latch_q[0].a, latch_q[0].pulses, COLS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_col_pattern();
        test_random_data();
        test_bcm_timing();
        test_enable_drop();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
